// File: rtl/hdr_ddr_rx_word.sv
// HDR-DDR word receiver: samples SDA on both SCL edges and deserialises DDR fields.
// Define HDR_DDR_RX_CRC_CHECK_EN to build the internal CRC5 register and CRC check.
module hdr_ddr_rx_word #(
    parameter int         WORD_BYTES = 2,
    parameter int         LSB_FIRST  = 1,
    parameter logic [3:0] TOKEN_VAL  = 4'b0011
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_sclgen_scl_pos_edge,
    input  logic                    i_sclgen_scl_neg_edge,
    input  logic                    i_sdahnd_rx_sda,
    input  logic                    i_ddrccc_rx_en,
    input  logic [2:0]              i_ddrccc_rx_mode,
    input  logic                    i_crc_init,
    output logic [8*WORD_BYTES-1:0] o_regfcrc_rx_data_out,
    output logic                    o_rx_data_valid,
    output logic                    o_ddrccc_rx_mode_done,
    output logic [1:0]              o_ddrccc_pre,
    output logic                    o_ddrccc_error,
    output logic [4:0]              o_rx_crc_value
);

    localparam int DW = 8 * WORD_BYTES;

    localparam logic [2:0] M_PRE  = 3'd0;
    localparam logic [2:0] M_DATA = 3'd1;
    localparam logic [2:0] M_PAR  = 3'd2;
    localparam logic [2:0] M_TOK  = 3'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [2:0]    mode_q;
    logic [5:0]    cnt;
    logic [5:0]    len;
    logic [DW-1:0] sh;
    logic [DW-1:0] sh_nxt;
    logic [1:0]    pa_nxt;
    logic [1:0]    exp_pa;
    logic [3:0]    tok_rx;
    logic          strobe;
    logic          last;
    logic          crc_err;

    // Coincident pos/neg strobes collapse into one sample.
    assign strobe = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign last   = (cnt == len - 6'd1);
    assign tok_rx = {sh_nxt[0], sh_nxt[1], sh_nxt[2], sh_nxt[3]};

    always_comb begin
        case (mode_q)
            M_PRE:   len = 6'd2;
            M_DATA:  len = 6'(DW);
            M_PAR:   len = 6'd2;
            M_TOK:   len = 6'd4;
            default: len = 6'd5;
        endcase
    end

    // Fields other than LSB-first data land with the first bit highest.
    always_comb begin
        sh_nxt = {sh[DW-2:0], i_sdahnd_rx_sda};
        if (mode_q == M_DATA && LSB_FIRST != 0)
            sh_nxt = {i_sdahnd_rx_sda, sh[DW-1:1]};
    end

    always_comb begin
        pa_nxt = 2'b01;
        for (int i = 0; i < DW; i++) begin
            if (i % 2 == 1)
                pa_nxt[1] = pa_nxt[1] ^ sh_nxt[i];
            else
                pa_nxt[0] = pa_nxt[0] ^ sh_nxt[i];
        end
    end

`ifdef HDR_DDR_RX_CRC_CHECK_EN
    logic [4:0] crc;
    logic       fb;

    assign fb      = crc[4] ^ i_sdahnd_rx_sda;
    assign crc_err = (sh_nxt[4:0] != crc);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst)
            crc <= 5'h1F;
        else if (i_crc_init)
            crc <= 5'h1F;
        else if (state == SHIFT && i_ddrccc_rx_en && strobe && mode_q == M_DATA)
            crc <= {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
`else
    logic unused_crc_init;
    assign unused_crc_init = i_crc_init;
    assign crc_err         = 1'b0;
`endif

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state                 <= IDLE;
            mode_q                <= M_PRE;
            cnt                   <= '0;
            sh                    <= '0;
            exp_pa                <= '0;
            o_regfcrc_rx_data_out <= '0;
            o_rx_data_valid       <= 1'b0;
            o_ddrccc_rx_mode_done <= 1'b0;
            o_ddrccc_pre          <= '0;
            o_ddrccc_error        <= 1'b0;
            o_rx_crc_value        <= '0;
        end else begin
            o_rx_data_valid       <= 1'b0;
            o_ddrccc_rx_mode_done <= 1'b0;
            o_ddrccc_error        <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_ddrccc_rx_en && i_ddrccc_rx_mode <= 3'd4) begin
                        mode_q <= i_ddrccc_rx_mode;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!i_ddrccc_rx_en) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (strobe) begin
                        sh  <= sh_nxt;
                        cnt <= cnt + 6'd1;
                        if (last) begin
                            cnt                   <= '0;
                            state                 <= DONE;
                            o_ddrccc_rx_mode_done <= 1'b1;
                            case (mode_q)
                                M_PRE: o_ddrccc_pre <= sh_nxt[1:0];
                                M_DATA: begin
                                    o_regfcrc_rx_data_out <= sh_nxt;
                                    o_rx_data_valid       <= 1'b1;
                                    exp_pa                <= pa_nxt;
                                end
                                M_PAR: o_ddrccc_error <= (sh_nxt[1:0] != exp_pa);
                                M_TOK: o_ddrccc_error <= (tok_rx != TOKEN_VAL);
                                default: begin
                                    o_rx_crc_value <= sh_nxt[4:0];
                                    o_ddrccc_error <= crc_err;
                                end
                            endcase
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdr_ddr_rx_word.sv
// Directed bench for hdr_ddr_rx_word (default parameters).
module tb_hdr_ddr_rx_word;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pos = 1'b0;
    logic        neg = 1'b0;
    logic        sda = 1'b0;
    logic        en = 1'b0;
    logic        crc_init = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] data;
    logic        valid;
    logic        done;
    logic [1:0]  pre;
    logic        err;
    logic [4:0]  crcv;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;

`ifdef HDR_DDR_RX_CRC_CHECK_EN
    localparam logic CRC_BAD_ERR = 1'b1;
`else
    localparam logic CRC_BAD_ERR = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [2:0]  mode;
        logic [31:0] bits;
        int          n;
        logic        init;
        logic [15:0] data;
        logic [1:0]  pre;
        logic        err;
        logic [4:0]  crc;
    } vec_t;

    vec_t vt[12];

    always #10 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    hdr_ddr_rx_word dut (
        .i_sys_clk            (clk),
        .i_sys_rst            (rst_n),
        .i_sclgen_scl_pos_edge(pos),
        .i_sclgen_scl_neg_edge(neg),
        .i_sdahnd_rx_sda      (sda),
        .i_ddrccc_rx_en       (en),
        .i_ddrccc_rx_mode     (mode),
        .i_crc_init           (crc_init),
        .o_regfcrc_rx_data_out(data),
        .o_rx_data_valid      (valid),
        .o_ddrccc_rx_mode_done(done),
        .o_ddrccc_pre         (pre),
        .o_ddrccc_error       (err),
        .o_rx_crc_value       (crcv)
    );

    function automatic vec_t mk(string nm, logic [2:0] m, logic [31:0] b, int n,
                                logic ini, logic [15:0] d, logic [1:0] p,
                                logic e, logic [4:0] c);
        vec_t v;
        v.name = nm; v.mode = m; v.bits = b; v.n = n; v.init = ini;
        v.data = d; v.pre = p; v.err = e; v.crc = c;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bits go out in index order, one strobe then two idle clocks per bit.
    task automatic send_bits(logic [31:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            sda = bits[i];
            if (i % 2 == 0) pos = 1'b1; else neg = 1'b1;
            @(posedge clk); #1;
            pos = 1'b0; neg = 1'b0;
            if (i != n - 1) begin
                @(posedge clk); @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_field(logic [2:0] m, logic [31:0] bits, int n);
        @(posedge clk); #1;
        en = 1'b1; mode = m;
        @(posedge clk); #1;
        send_bits(bits, n);
        en = 1'b0;
    endtask

    task automatic pulse_crc_init();
        @(posedge clk); #1;
        crc_init = 1'b1;
        @(posedge clk); #1;
        crc_init = 1'b0;
    endtask

    initial begin
        int dc0;

        vt[0]  = mk("pre01",     3'd0, 32'h2,    2,  1'b0, 16'h0000, 2'b01, 1'b0, 5'h00);
        vt[1]  = mk("data_d4a1", 3'd1, 32'hD4A1, 16, 1'b1, 16'hD4A1, 2'b01, 1'b0, 5'h00);
        vt[2]  = mk("par_d4a1",  3'd2, 32'h3,    2,  1'b0, 16'hD4A1, 2'b01, 1'b0, 5'h00);
        vt[3]  = mk("data_0001", 3'd1, 32'h1,    16, 1'b1, 16'h0001, 2'b01, 1'b0, 5'h00);
        vt[4]  = mk("par_ok",    3'd2, 32'h0,    2,  1'b0, 16'h0001, 2'b01, 1'b0, 5'h00);
        vt[5]  = mk("par_bad",   3'd2, 32'h1,    2,  1'b0, 16'h0001, 2'b01, 1'b1, 5'h00);
        vt[6]  = mk("tok_ok",    3'd3, 32'h3,    4,  1'b0, 16'h0001, 2'b01, 1'b0, 5'h00);
        vt[7]  = mk("tok_bad",   3'd3, 32'h5,    4,  1'b0, 16'h0001, 2'b01, 1'b1, 5'h00);
        vt[8]  = mk("data_crc1", 3'd1, 32'h1,    16, 1'b1, 16'h0001, 2'b01, 1'b0, 5'h00);
        vt[9]  = mk("crc_ok",    3'd4, 32'h16,   5,  1'b0, 16'h0001, 2'b01, 1'b0, 5'h0D);
        vt[10] = mk("data_crc2", 3'd1, 32'h1,    16, 1'b1, 16'h0001, 2'b01, 1'b0, 5'h0D);
        vt[11] = mk("crc_bad",   3'd4, 32'h06,   5,  1'b0, 16'h0001, 2'b01, CRC_BAD_ERR, 5'h0C);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  32'(data),  32'h0);
        chk("rst_done",  32'(done),  32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_pre",   32'(pre),   32'h0);
        chk("rst_err",   32'(err),   32'h0);
        chk("rst_crc",   32'(crcv),  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            if (vt[k].init) pulse_crc_init();
            dc0 = done_cnt;
            send_field(vt[k].mode, vt[k].bits, vt[k].n);
            @(negedge clk);
            chk({vt[k].name, "_done"},  32'(done),  32'h1);
            chk({vt[k].name, "_valid"}, 32'(valid), 32'(vt[k].mode == 3'd1));
            chk({vt[k].name, "_data"},  32'(data),  32'(vt[k].data));
            chk({vt[k].name, "_pre"},   32'(pre),   32'(vt[k].pre));
            chk({vt[k].name, "_err"},   32'(err),   32'(vt[k].err));
            chk({vt[k].name, "_crc"},   32'(crcv),  32'(vt[k].crc));
            @(negedge clk);
            chk({vt[k].name, "_done_fall"},  32'(done),  32'h0);
            chk({vt[k].name, "_valid_fall"}, 32'(valid), 32'h0);
            #1;
            chk({vt[k].name, "_done_cnt"}, 32'(done_cnt - dc0), 32'h1);
        end

        // Mode change during SHIFT is ignored.
        dc0 = done_cnt;
        @(posedge clk); #1;
        en = 1'b1; mode = 3'd0;
        @(posedge clk); #1;
        mode = 3'd1;
        send_bits(32'h1, 2);
        en = 1'b0;
        @(negedge clk);
        chk("modechg_done",  32'(done),  32'h1);
        chk("modechg_valid", 32'(valid), 32'h0);
        chk("modechg_pre",   32'(pre),   32'h2);
        chk("modechg_data",  32'(data),  32'h0001);
        @(negedge clk); #1;
        chk("modechg_cnt", 32'(done_cnt - dc0), 32'h1);

        // Reserved mode never completes.
        dc0 = done_cnt;
        @(posedge clk); #1;
        en = 1'b1; mode = 3'd5;
        @(posedge clk); #1;
        send_bits(32'hFF, 6);
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        chk("rsvd_no_done", 32'(done_cnt - dc0), 32'h0);

        // Abort after 5 of 16 data bits, then a full word.
        dc0 = done_cnt;
        @(posedge clk); #1;
        en = 1'b1; mode = 3'd1;
        @(posedge clk); #1;
        send_bits(32'h1F, 5);
        en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'h0);
        chk("abort_data",    32'(data),           32'h0001);
        send_field(3'd1, 32'h5A3C, 16);
        @(negedge clk);
        chk("after_abort_done", 32'(done), 32'h1);
        chk("after_abort_data", 32'(data), 32'h5A3C);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a field.
        @(posedge clk); #1;
        en = 1'b1; mode = 3'd1;
        @(posedge clk); #1;
        send_bits(32'h7, 3);
        #3;
        rst_n = 1'b0;
        #2;
        chk("mrst_data",  32'(data),  32'h0);
        chk("mrst_pre",   32'(pre),   32'h0);
        chk("mrst_crc",   32'(crcv),  32'h0);
        chk("mrst_done",  32'(done),  32'h0);
        chk("mrst_valid", 32'(valid), 32'h0);
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_field(3'd0, 32'h3, 2);
        @(negedge clk);
        chk("mrst_pre_done", 32'(done), 32'h1);
        chk("mrst_pre_val",  32'(pre),  32'h3);
        chk("mrst_pre_data", 32'(data), 32'h0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
